// File: rtl/pi_loop_scheduler_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pi_loop_pkg
// Purpose  : Shared definitions for the PI loop scheduler: controller state
//            encoding, default word format and default command clamp limits.
// Ports    : none (package)
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
package pi_loop_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int FBITS_DEF = 7;

  // +25.0 / -25.0 in Q8.7
  localparam logic [15:0] CMD_MAX_DEF = 16'h0C80;
  localparam logic [15:0] CMD_MIN_DEF = 16'hF380;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_APPLY     = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pi_loop_scheduler_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pi_loop_scheduler_if
// Purpose  : Groups the loop-control signals between the scheduler and its
//            environment (demand/feedback source, PI controller, actuator).
// Ports    : master = scheduler side, slave = environment side.
//            run_i, setpoint_i, feedback_i, pi_i, pi_finish_i  -> scheduler
//            pi_enable_o, delta_o, cmd_o, cmd_valid_o, fault_o,
//            overrun_cnt_o                                     <- scheduler
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
interface pi_loop_scheduler_if
  import pi_loop_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             run_i;
  logic [WIDTH-1:0] setpoint_i;
  logic [WIDTH-1:0] feedback_i;
  logic             pi_enable_o;
  logic [WIDTH-1:0] delta_o;
  logic [WIDTH-1:0] pi_i;
  logic             pi_finish_i;
  logic [WIDTH-1:0] cmd_o;
  logic             cmd_valid_o;
  logic             fault_o;
  logic [7:0]       overrun_cnt_o;

  modport master (
    input  run_i, setpoint_i, feedback_i, pi_i, pi_finish_i,
    output pi_enable_o, delta_o, cmd_o, cmd_valid_o, fault_o, overrun_cnt_o
  );

  modport slave (
    output run_i, setpoint_i, feedback_i, pi_i, pi_finish_i,
    input  pi_enable_o, delta_o, cmd_o, cmd_valid_o, fault_o, overrun_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/pi_loop_scheduler_period_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : period_timer
// Purpose  : Free-running sample-period counter 0..PERIOD-1. tick marks the
//            last count of each period. hold forces the count to zero and
//            suppresses tick.
// Ports    : clk_i, reset_i (sync, active high), hold (in), tick (out)
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module period_timer
  import pi_loop_pkg::*;
#(
  parameter int PERIOD = 5000
) (
  input  wire logic clk_i,
  input  wire logic reset_i,
  input  wire logic hold,
  output logic      tick
);
  localparam int            CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk_i) begin
    if (reset_i || hold) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = !hold && (count == LAST);
endmodule
`default_nettype wire

// File: rtl/pi_loop_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pi_loop_scheduler
// Purpose  : Paces a PI position loop. Every PERIOD cycles it captures the
//            saturated error setpoint-feedback, pulses the PI controller,
//            waits for its completion edge, clamps the result and publishes
//            it as the actuator command. A missing completion within TIMEOUT
//            cycles latches a fault and forces a zero command.
// Ports    : clk_i, reset_i (sync, active high), bus (pi_loop_scheduler_if
//            master modport).
// Options  : PI_LOOP_OVERRUN_CNT_EN - when defined, overrun_cnt_o counts
//            sample ticks dropped because a transaction was still running
//            (saturating at 255). Otherwise overrun_cnt_o is constant 0.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module pi_loop_scheduler
  import pi_loop_pkg::*;
#(
  parameter int               WIDTH   = WIDTH_DEF,
  parameter int               FBITS   = FBITS_DEF,
  parameter int               PERIOD  = 5000,
  parameter int               TIMEOUT = 64,
  parameter logic [WIDTH-1:0] CMD_MAX = WIDTH'(CMD_MAX_DEF),
  parameter logic [WIDTH-1:0] CMD_MIN = WIDTH'(CMD_MIN_DEF)
) (
  input  wire logic              clk_i,
  input  wire logic              reset_i,
  pi_loop_scheduler_if.master    bus
);
  // The word format must leave room for the sign bit.
  generate
    if (FBITS >= WIDTH) begin : g_bad_fbits
      $error("FBITS must be smaller than WIDTH");
    end
  endgenerate

  localparam int            TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  state_t           state;
  state_t           state_next;
  logic             tick;
  logic             hold;
  logic             pi_enable;
  logic             finish_q;
  logic             done_edge;
  logic             timeout_hit;
  logic [TW-1:0]    wait_cnt;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] delta_sat;
  logic [WIDTH-1:0] cmd_clamped;
  logic [WIDTH-1:0] delta_q;
  logic [WIDTH-1:0] cmd_q;
  logic             cmd_valid_q;
  logic             fault_q;

  period_timer #(.PERIOD(PERIOD)) u_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .hold    (hold),
    .tick    (tick)
  );

  // Only a low-to-high transition counts, so a finish level left high by the
  // previous transaction can never complete the current one.
  assign done_edge   = bus.pi_finish_i && !finish_q;
  assign timeout_hit = (wait_cnt == WAIT_LAST);

  // Error computed one bit wider, then saturated back to WIDTH.
  assign diff = {bus.setpoint_i[WIDTH-1], bus.setpoint_i}
              - {bus.feedback_i[WIDTH-1], bus.feedback_i};

  always_comb begin
    delta_sat = diff[WIDTH-1:0];
    if (diff[WIDTH] != diff[WIDTH-1]) begin
      delta_sat = diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    cmd_clamped = bus.pi_i;
    if ($signed(bus.pi_i) > $signed(CMD_MAX)) begin
      cmd_clamped = CMD_MAX;
    end else if ($signed(bus.pi_i) < $signed(CMD_MIN)) begin
      cmd_clamped = CMD_MIN;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Dropping run_i only takes effect outside a transaction.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (bus.run_i) state_next = ST_WAIT_TICK;
      ST_WAIT_TICK: begin
        if (!bus.run_i)  state_next = ST_IDLE;
        else if (tick)   state_next = ST_ISSUE;
      end
      ST_ISSUE:     state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (done_edge)        state_next = ST_APPLY;   // completion beats timeout
        else if (timeout_hit) state_next = ST_FAULT;
      end
      ST_APPLY:     state_next = bus.run_i ? ST_WAIT_TICK : ST_IDLE;
      ST_FAULT:     if (!bus.run_i) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    pi_enable = 1'b0;
    hold      = 1'b1;
    pi_enable = (state == ST_ISSUE);
    hold      = (state == ST_IDLE) || (state == ST_FAULT);
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      finish_q    <= 1'b0;
      wait_cnt    <= '0;
      delta_q     <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      finish_q    <= bus.pi_finish_i;
      cmd_valid_q <= 1'b0;
      wait_cnt    <= (state == ST_WAIT_DONE) ? wait_cnt + 1'b1 : '0;
      if (state == ST_WAIT_TICK && bus.run_i && tick) begin
        delta_q <= delta_sat;
      end
      if (state == ST_WAIT_DONE && done_edge) begin
        cmd_q       <= cmd_clamped;
        cmd_valid_q <= 1'b1;
      end else if (state == ST_WAIT_DONE && timeout_hit) begin
        cmd_q       <= '0;
        cmd_valid_q <= 1'b1;
        fault_q     <= 1'b1;
      end
      if (state == ST_IDLE && bus.run_i) begin
        fault_q <= 1'b0;
      end
    end
  end

`ifdef PI_LOOP_OVERRUN_CNT_EN
  // A tick that lands while a transaction is still busy is dropped.
  logic       overrun;
  logic [7:0] overrun_cnt;

  assign overrun = tick && ((state == ST_WAIT_DONE) || (state == ST_APPLY));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      overrun_cnt <= '0;
    end else if (overrun && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

  assign bus.overrun_cnt_o = overrun_cnt;
`else
  assign bus.overrun_cnt_o = 8'h00;
`endif

  assign bus.pi_enable_o = pi_enable;
  assign bus.delta_o     = delta_q;
  assign bus.cmd_o       = cmd_q;
  assign bus.cmd_valid_o = cmd_valid_q;
  assign bus.fault_o     = fault_q;
endmodule
`default_nettype wire

// File: tb/tb_pi_loop_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_pi_loop_scheduler
// Purpose  : Self-checking bench for pi_loop_scheduler. Stimulus computes the
//            expected PI pulse and command strobe (cycle and value) from the
//            loop timing rules and queues them; a monitor pops and compares
//            whenever the scheduler presents pi_enable_o or cmd_valid_o.
//            A responder process plays the PI controller.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_pi_loop_scheduler;
  localparam int P  = 48;   // short period keeps the run brief
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pi_loop_scheduler_if #(.WIDTH(16)) bus ();

  pi_loop_scheduler #(
    .WIDTH   (16),
    .FBITS   (7),
    .PERIOD  (P),
    .TIMEOUT (TO),
    .CMD_MAX (16'h0C80),
    .CMD_MIN (16'hF380)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  typedef struct { int cyc; logic [15:0] val; logic fault; } exp_t;
  typedef struct { int mode; int d; logic [15:0] val; } rsp_t;

  exp_t pe_q[$];
  exp_t cv_q[$];
  rsp_t rsp_q[$];

  int errors    = 0;
  int checks    = 0;
  int next_tick = 0;
  int ovr_model = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model_delta(input logic [15:0] sp, input logic [15:0] fb);
    int a = $signed(sp);
    int b = $signed(fb);
    int d = a - b;
    if (d > 32767)  d = 32767;
    if (d < -32768) d = -32768;
    return 16'(d);
  endfunction

  function automatic logic [15:0] model_cmd(input logic [15:0] v);
    int x = $signed(v);
    if (x > 3200)  x = 3200;
    if (x < -3200) x = -3200;
    return 16'(x);
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start_run();
    bus.run_i = 1'b1;
    next_tick = cyc + P;
  endtask

  task automatic check_ovr(input string name);
    int exp;
`ifdef PI_LOOP_OVERRUN_CNT_EN
    exp = (ovr_model > 255) ? 255 : ovr_model;
`else
    exp = 0;
`endif
    check(name, 32'(bus.overrun_cnt_o), 32'(exp));
  endtask

  // mode 0: finish edge D cycles after the pulse; 1: never finishes;
  // 2: finish stays high from the prior sample for D cycles, then a fresh edge.
  task automatic do_txn(input logic [15:0] sp, input logic [15:0] fb, input int mode,
                        input int d, input logic [15:0] val, input bit drop_run);
    int t0, issue, done, t, de;
    bus.setpoint_i = sp;
    bus.feedback_i = fb;
    t0    = next_tick;
    issue = t0 + 1;
    pe_q.push_back('{issue, model_delta(sp, fb), 1'b0});
    rsp_q.push_back('{mode, d, val});
    if (mode == 1) begin
      done = issue + TO + 1;
      cv_q.push_back('{done, 16'h0000, 1'b1});
      t = t0 + P;
      while (t <= done - 1) begin ovr_model++; t += P; end
    end else begin
      de   = (mode == 2) ? d + 1 : d;
      done = issue + de + 1;
      cv_q.push_back('{done, model_cmd(val), 1'b0});
      t = t0 + P;
      while (t <= done) begin ovr_model++; t += P; end
      next_tick = t;
    end
    if (drop_run) begin
      wait_until(issue);
      bus.run_i = 1'b0;
    end
    wait_until(done + 1);
  endtask

  // PI controller stand-in
  initial begin : responder
    rsp_t r;
    bus.pi_i        = 16'h0000;
    bus.pi_finish_i = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.pi_enable_o === 1'b1 && rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        if (r.mode == 2) begin
          repeat (r.d) @(negedge clk);
          bus.pi_finish_i = 1'b0;
          @(negedge clk);
          bus.pi_i        = r.val;
          bus.pi_finish_i = 1'b1;
        end else begin
          bus.pi_finish_i = 1'b0;
          if (r.mode == 0) begin
            repeat (r.d) @(negedge clk);
            bus.pi_i        = r.val;
            bus.pi_finish_i = 1'b1;
          end
        end
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.pi_enable_o === 1'b1) begin
      if (pe_q.size() == 0) begin
        check("pi_enable_unexpected", 32'(bus.pi_enable_o), 32'd0);
      end else begin
        e = pe_q.pop_front();
        check("pi_enable_cycle", 32'(cyc), 32'(e.cyc));
        check("delta", 32'(bus.delta_o), 32'(e.val));
      end
    end
    if (bus.cmd_valid_o === 1'b1) begin
      if (cv_q.size() == 0) begin
        check("cmd_valid_unexpected", 32'(bus.cmd_valid_o), 32'd0);
      end else begin
        e = cv_q.pop_front();
        check("cmd_valid_cycle", 32'(cyc), 32'(e.cyc));
        check("cmd", 32'(bus.cmd_o), 32'(e.val));
        check("fault_at_strobe", 32'(bus.fault_o), 32'(e.fault));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pi_enable"}, 32'(bus.pi_enable_o), 32'd0);
    check({tag, "_delta"},     32'(bus.delta_o),     32'd0);
    check({tag, "_cmd"},       32'(bus.cmd_o),       32'd0);
    check({tag, "_cmd_valid"}, 32'(bus.cmd_valid_o), 32'd0);
    check({tag, "_fault"},     32'(bus.fault_o),     32'd0);
    check({tag, "_overrun"},   32'(bus.overrun_cnt_o), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int t0;
    rst            = 1'b1;
    bus.run_i      = 1'b0;
    bus.setpoint_i = 16'h0000;
    bus.feedback_i = 16'h0000;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    start_run();
    do_txn(16'h0100, 16'h0080, 0, 3, 16'h1000, 1'b0);
    do_txn(16'h7F00, 16'h8100, 0, 2, 16'hE000, 1'b0);
    do_txn(16'h8100, 16'h7F00, 0, 1, 16'h0040, 1'b0);
    for (int i = 0; i < 6; i++) begin
      do_txn(16'($urandom), 16'($urandom), 0, int'($urandom_range(1, 40)),
             16'($urandom), 1'b0);
    end
    do_txn(16'h0200, 16'h0010, 2, 4, 16'h0123, 1'b0);   // stale finish level
    do_txn(16'h0010, 16'h0020, 0, 55, 16'hFF00, 1'b0);  // overruns one tick
    check_ovr("overrun_after_slow_pi");

    // run dropped mid-transaction: completes, then idles
    do_txn(16'h0300, 16'h0100, 0, 5, 16'h0500, 1'b1);
    repeat (3) @(negedge clk);
    start_run();

    // timeout into fault, then recovery
    do_txn(16'h0050, 16'h0010, 1, 0, 16'h0000, 1'b0);
    repeat (4) @(negedge clk);
    check("fault_held", 32'(bus.fault_o), 32'd1);
    check("fault_cmd_zero", 32'(bus.cmd_o), 32'd0);
    bus.run_i = 1'b0;
    repeat (2) @(negedge clk);
    check("fault_until_restart", 32'(bus.fault_o), 32'd1);
    start_run();
    @(negedge clk);
    check("fault_cleared", 32'(bus.fault_o), 32'd0);
    do_txn(16'h0400, 16'h0100, 0, 6, 16'h0040, 1'b0);
    check_ovr("overrun_after_fault");

    // reset asserted while waiting for the PI
    bus.setpoint_i = 16'h0500;
    bus.feedback_i = 16'h0100;
    t0 = next_tick;
    pe_q.push_back('{t0 + 1, 16'h0400, 1'b0});
    rsp_q.push_back('{1, 0, 16'h0000});
    wait_until(t0 + 12);
    rst       = 1'b1;
    bus.run_i = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst       = 1'b0;
    ovr_model = 0;
    @(negedge clk);
    start_run();
    do_txn(16'h0000, 16'h0100, 0, 7, 16'hF000, 1'b0);
    check_ovr("overrun_after_reset");

    repeat (5) @(negedge clk);
    check("pi_enable_expected_left", 32'(pe_q.size()), 32'd0);
    check("cmd_valid_expected_left", 32'(cv_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pi_loop_scheduler.md
PI_LOOP_SCHEDULER -- requirements
Module: pi_loop_scheduler

Interface
REQ-001 Parameter WIDTH, default 16, signed fixed-point word width (sign+int+frac).
REQ-002 Parameter FBITS, default 7, fractional bits.
REQ-003 Parameter PERIOD, default 5000, clock cycles per control sample (10 kHz at 50 MHz).
REQ-004 Parameter TIMEOUT, default 64, maximum cycles waited for PI completion.
REQ-005 Parameters CMD_MAX and CMD_MIN, defaults 16'h0C80 (+25.0) and 16'hF380 (-25.0), command clamp limits.
REQ-006 clk_i  input  1  single clock, 50 MHz; reset_i  input  1  synchronous active-high reset.
REQ-007 run_i  input  1  loop enable (level).
REQ-008 setpoint_i, feedback_i  input  WIDTH each  signed demand and measured position.
REQ-009 pi_enable_o  output  1  one-cycle start pulse to the PI controller.
REQ-010 delta_o  output  WIDTH  error word presented to the PI controller.
REQ-011 pi_i  input  WIDTH  PI result; pi_finish_i  input  1  PI completion level.
REQ-012 cmd_o  output  WIDTH  clamped actuator command; cmd_valid_o  output  1  one-cycle new-command strobe.
REQ-013 fault_o  output  1  timeout fault flag; overrun_cnt_o  output  8  overrun counter (see Configuration).

Function
REQ-014 States: IDLE, WAIT_TICK, ISSUE, WAIT_DONE, APPLY, FAULT.
REQ-015 Period counter runs 0..PERIOD-1 while state is not IDLE/FAULT, wraps to 0; tick = counter at PERIOD-1; counter held at 0 in IDLE/FAULT.
REQ-016 IDLE -> WAIT_TICK when run_i=1; clears fault_o on this transition.
REQ-017 WAIT_TICK: run_i=0 -> IDLE; on tick, register delta = sat(setpoint_i - feedback_i), difference computed in WIDTH+1 bits, saturated to [2^(WIDTH-1)-1, -2^(WIDTH-1)]; -> ISSUE.
REQ-018 ISSUE: pi_enable_o=1 for exactly this cycle; delta_o stable from ISSUE until leaving WAIT_DONE; -> WAIT_DONE.
REQ-019 WAIT_DONE: completion = rising edge of pi_finish_i (high now, low previous cycle); stale high level from prior transaction never counts.
REQ-020 On completion, cmd_o <= clamp(pi_i, CMD_MIN, CMD_MAX) signed, cmd_valid_o=1 next cycle (APPLY); latency completion-edge to strobe = 1 cycle.
REQ-021 APPLY lasts one cycle -> WAIT_TICK if run_i=1, else IDLE; cmd_o holds last value.
REQ-022 Tick occurring in WAIT_DONE or APPLY is an overrun: tick is dropped, transaction continues, next sample waits for following tick.
REQ-023 run_i=0 during ISSUE/WAIT_DONE does not abort; transaction completes and publishes, then IDLE.
REQ-024 WAIT_DONE with no completion edge for TIMEOUT cycles -> FAULT: fault_o=1, cmd_o=0, one cmd_valid_o pulse on entry.
REQ-025 FAULT exits to IDLE only when run_i=0; fault_o stays 1 until IDLE->WAIT_TICK or reset.
REQ-026 Completion edge and timeout expiry in same cycle: completion wins.

Reset
REQ-027 reset_i=1 at clock edge: state=IDLE, counters=0, pi_enable_o=0, delta_o=0, cmd_o=0, cmd_valid_o=0, fault_o=0, overrun_cnt_o=0; takes priority in every state including mid-transaction.

Configuration
REQ-028 With PI_LOOP_OVERRUN_CNT_EN defined: overrun_cnt_o increments per REQ-022 overrun, saturates at 255, cleared by reset only.
REQ-029 Without PI_LOOP_OVERRUN_CNT_EN: no counter logic; overrun_cnt_o tied to 0; overrun behaviour per REQ-022 unchanged.

Structure
REQ-030 Shared package pi_loop_pkg holds state enum typedef, default WIDTH/FBITS, CMD_MAX/CMD_MIN defaults.
REQ-031 One sub-module period_timer (PERIOD counter, tick output, hold/clear input).

Verification
REQ-032 run_i=1, setpoint 16'h0100, feedback 16'h0080 -> delta_o=16'h0080 with single pi_enable_o pulse one cycle after tick.
REQ-033 setpoint 16'h7F00, feedback 16'h8100 -> delta_o=16'h7FFF; reversed -> 16'h8000.
REQ-034 PI model returns 16'h1000 -> cmd_o=16'h0C80; returns 16'hE000 -> 16'hF380; returns 16'h0040 -> 16'h0040; each with one cmd_valid_o pulse one cycle after finish edge.
REQ-035 PI model never raises finish -> after 64 cycles fault_o=1, cmd_o=0, one strobe; run_i low then high -> fault_o=0, loop resumes.
REQ-036 PI finish delayed beyond PERIOD -> one tick dropped, overrun_cnt_o=1 (macro defined) or 0 (undefined); pi_finish_i held high from previous sample never accepted.
REQ-037 reset_i asserted during WAIT_DONE -> next cycle all outputs at reset values, state IDLE.
